// File: rtl/fetch_pc_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_pc_ctrl_pkg : shared front-end types for the fetch PC controller.
// Revision: 1.0
// ---------------------------------------------------------------------------
`ifndef NUM_SUPER
`define NUM_SUPER 2
`endif
`ifndef FETCH_BLOCK_BYTES
`define FETCH_BLOCK_BYTES 8
`endif

package fetch_pc_ctrl_pkg;

  localparam int          C_NUM_SUPER   = `NUM_SUPER;
  localparam logic [63:0] C_BLOCK_BYTES = 64'(`FETCH_BLOCK_BYTES);
  localparam logic [63:0] C_INST_BYTES  = 64'd4;

  typedef struct packed {
    logic        rollback_en;
    logic [1:0]  take_branch_out;
    logic [63:0] take_branch_target_out;
    logic [1:0]  inst_valid;
  } BP_F_OUT_t;

  typedef struct packed {
    logic [1:0] inst_valid;
  } F_BP_OUT_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    MISS  = 2'd1,
    DRAIN = 2'd2
  } FETCH_STATE_t;

  typedef struct packed {
    logic [1:0]       valid;
    logic [1:0][31:0] IR;
    logic [1:0][63:0] NPC;
  } IF_BUNDLE_t;

  function automatic logic [63:0] block_align(input logic [63:0] addr);
    return addr & ~(C_BLOCK_BYTES - 64'd1);
  endfunction

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] inc);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, inc};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_pc_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_pc_ctrl_if : I-cache, predictor and dispatch signals of the fetch stage.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface fetch_pc_ctrl_if
  import fetch_pc_ctrl_pkg::*;
#(
  parameter int NUM_SUPER = C_NUM_SUPER
) ();

  logic [63:0]                Icache_data;
  logic                       Icache_valid;
  logic [63:0]                Icache_addr;
  logic                       Icache_req;
  BP_F_OUT_t                  BP_F_out;
  logic                       D_stall;
  logic [NUM_SUPER-1:0][31:0] if_IR_out;
  logic [NUM_SUPER-1:0][63:0] if_NPC_out;
  F_BP_OUT_t                  F_BP_out;
  logic [63:0]                if_PC_reg;

  modport master (
    input  Icache_data, Icache_valid, BP_F_out, D_stall,
    output Icache_addr, Icache_req, if_IR_out, if_NPC_out, F_BP_out, if_PC_reg
  );

  modport slave (
    output Icache_data, Icache_valid, BP_F_out, D_stall,
    input  Icache_addr, Icache_req, if_IR_out, if_NPC_out, F_BP_out, if_PC_reg
  );

endinterface

`default_nettype wire

// File: rtl/fetch_pc_ctrl_align.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_pc_ctrl_align : slot extraction, NPCs and sequential next PC.
// Revision: 1.0
// ---------------------------------------------------------------------------
module fetch_pc_ctrl_align
  import fetch_pc_ctrl_pkg::*;
(
  input  wire logic [63:0] pc,
  input  wire logic [63:0] data,
  output IF_BUNDLE_t       slots,
  output logic [63:0]      seq_next
);

  logic [63:0] w_pc_p4;
  logic [63:0] w_pc_p8;

  assign w_pc_p4 = pc + C_INST_BYTES;
  assign w_pc_p8 = pc + (C_INST_BYTES << 1);

  always_comb begin
    slots    = '0;
    seq_next = w_pc_p8;
    if (pc[2]) begin
      // Upper word only: the second slot would belong to the next block.
      slots.valid  = 2'b01;
      slots.IR[0]  = data[63:32];
      slots.NPC[0] = w_pc_p4;
      seq_next     = w_pc_p4;
    end else begin
      slots.valid  = 2'b11;
      slots.IR[0]  = data[31:0];
      slots.IR[1]  = data[63:32];
      slots.NPC[0] = w_pc_p4;
      slots.NPC[1] = w_pc_p8;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_pc_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_pc_ctrl : 2-wide fetch PC generator and IF/ID bundle register.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/miss/squash counters.
// Revision: 1.0
// ---------------------------------------------------------------------------
module fetch_pc_ctrl
  import fetch_pc_ctrl_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  wire logic       clock,
  input  wire logic       reset,
  fetch_pc_ctrl_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     fetch_cnt,
  output logic [31:0]     miss_cycle_cnt,
  output logic [31:0]     squash_cnt
`endif
);

  FETCH_STATE_t r_state;
  logic [63:0]  r_pc;
  IF_BUNDLE_t   r_bundle;
  logic         r_req;

  IF_BUNDLE_t   w_slots;
  logic [63:0]  w_seq_next;
  logic [63:0]  w_target;
  logic         w_bundle_valid;
  logic         w_rollback;
  logic         w_taken;
  logic         w_taken_go;
  logic         w_redirect_drain;
  logic         w_unused_bp;

  fetch_pc_ctrl_align u_align (
    .pc       (r_pc),
    .data     (bus.Icache_data),
    .slots    (w_slots),
    .seq_next (w_seq_next)
  );

  assign w_target       = {bus.BP_F_out.take_branch_target_out[63:2], 2'b00};
  assign w_bundle_valid = |r_bundle.valid;
  assign w_rollback     = bus.BP_F_out.rollback_en;
  assign w_taken        = w_bundle_valid && (|bus.BP_F_out.take_branch_out);
  assign w_taken_go     = w_taken && !bus.D_stall;
  // A redirect with a request still outstanding must wait for its response.
  assign w_redirect_drain = (r_state == MISS) || ((r_state == DRAIN) && !bus.Icache_valid);
  assign w_unused_bp    = ^{bus.BP_F_out.inst_valid, bus.BP_F_out.take_branch_target_out[1:0]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= FETCH;
      r_pc     <= RESET_PC;
      r_bundle <= '0;
      r_req    <= 1'b0;
    end else begin
      r_req <= 1'b1;
      if (w_rollback || w_taken_go) begin
        r_pc     <= w_target;
        r_bundle <= '0;
        if (w_redirect_drain) begin
          r_state <= DRAIN;
          r_req   <= 1'b0;
        end else begin
          r_state <= FETCH;
        end
      end else if (bus.D_stall) begin
        if ((r_state == FETCH) && !bus.Icache_valid) begin
          r_state <= MISS;
        end else if (r_state == DRAIN) begin
          if (bus.Icache_valid) r_state <= FETCH;
          else                  r_req   <= 1'b0;
        end
      end else if (r_state == DRAIN) begin
        r_bundle <= '0;
        if (bus.Icache_valid) r_state <= FETCH;
        else                  r_req   <= 1'b0;
      end else if (bus.Icache_valid) begin
        r_bundle <= w_slots;
        r_pc     <= w_seq_next;
        r_state  <= FETCH;
      end else begin
        r_bundle <= '0;
        r_state  <= MISS;
      end
    end
  end

  assign bus.Icache_addr         = block_align(r_pc);
  assign bus.Icache_req          = r_req;
  assign bus.if_IR_out           = r_bundle.IR;
  assign bus.if_NPC_out          = r_bundle.NPC;
  assign bus.F_BP_out.inst_valid = r_bundle.valid;
  assign bus.if_PC_reg           = r_pc;

`ifdef FETCH_PERF_CNT_EN
  logic       w_load;
  logic [1:0] w_fetch_inc;
  logic       w_squash;

  assign w_load      = (r_state != DRAIN) && bus.Icache_valid && !bus.D_stall
                       && !w_rollback && !w_taken;
  assign w_fetch_inc = w_load ? (2'(w_slots.valid[0]) + 2'(w_slots.valid[1])) : 2'd0;
  assign w_squash    = w_rollback ? w_bundle_valid
                                  : (w_taken_go && bus.Icache_valid && (r_state != DRAIN));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_cnt      <= '0;
      miss_cycle_cnt <= '0;
      squash_cnt     <= '0;
    end else begin
      fetch_cnt      <= sat_add32(fetch_cnt, 32'(w_fetch_inc));
      miss_cycle_cnt <= sat_add32(miss_cycle_cnt, 32'(r_state == MISS));
      squash_cnt     <= sat_add32(squash_cnt, 32'(w_squash));
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_pc_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fetch_pc_ctrl : scoreboard bench for the fetch PC controller.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_fetch_pc_ctrl;
  import fetch_pc_ctrl_pkg::*;

  typedef struct {
    logic [1:0]  v;
    logic [31:0] ir0;
    logic [31:0] ir1;
    logic [63:0] npc0;
    logic [63:0] npc1;
  } exp_t;

  logic clock;
  logic reset;
  logic last_stall;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  fetch_pc_ctrl_if bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, miss_cycle_cnt, squash_cnt;
`endif

  fetch_pc_ctrl #(.RESET_PC(64'h0)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt      (fetch_cnt),
    .miss_cycle_cnt (miss_cycle_cnt),
    .squash_cnt     (squash_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) last_stall <= bus.D_stall;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] inst(input logic [63:0] a);
    return 32'hC0DE_0000 ^ a[31:0];
  endfunction

  function automatic logic [63:0] blk(input logic [63:0] b);
    return {inst(b + 64'd4), inst(b)};
  endfunction

  function automatic exp_t mk_exp(input logic [63:0] pc);
    exp_t e;
    e.ir0  = inst(pc);
    e.npc0 = pc + 64'd4;
    if (pc[2]) begin
      e.v    = 2'b01;
      e.ir1  = '0;
      e.npc1 = '0;
    end else begin
      e.v    = 2'b11;
      e.ir1  = inst(pc + 64'd4);
      e.npc1 = pc + 64'd8;
    end
    return e;
  endfunction

  // mode 0: no response, 1: respond when requested, 2: respond regardless
  task automatic cycle(input int mode, input bit rb, input logic [1:0] tk,
                       input logic [63:0] tgt, input bit stall);
    bus.Icache_valid = (mode == 2) || ((mode == 1) && bus.Icache_req);
    bus.Icache_data  = blk(bus.Icache_addr);
    bus.BP_F_out     = '0;
    bus.BP_F_out.rollback_en            = rb;
    bus.BP_F_out.take_branch_out        = tk;
    bus.BP_F_out.take_branch_target_out = tgt;
    bus.D_stall      = stall;
    @(posedge clock);
    #1;
  endtask

  task automatic hit(input logic [63:0] pc);
    sb.push_back(mk_exp(pc));
    cycle(1, 1'b0, 2'b00, 64'd0, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk_eq({tag, "_req"},   64'(bus.Icache_req), 64'd0);
    chk_eq({tag, "_addr"},  bus.Icache_addr, 64'd0);
    chk_eq({tag, "_valid"}, 64'(bus.F_BP_out.inst_valid), 64'd0);
    chk_eq({tag, "_ir"},    64'(bus.if_IR_out), 64'd0);
    chk_eq({tag, "_npc0"},  bus.if_NPC_out[0], 64'd0);
    chk_eq({tag, "_npc1"},  bus.if_NPC_out[1], 64'd0);
    chk_eq({tag, "_pc"},    bus.if_PC_reg, 64'd0);
  endtask

  always @(negedge clock) begin : p_mon
    exp_t e;
    if (reset && (bus.F_BP_out.inst_valid != 2'b00) && !last_stall) begin
      if (sb.size() == 0) begin
        chk_eq("sb_unexpected_bundle", 64'(bus.F_BP_out.inst_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        chk_eq("bnd_valid", 64'(bus.F_BP_out.inst_valid), 64'(e.v));
        chk_eq("bnd_ir0",   64'(bus.if_IR_out[0]), 64'(e.ir0));
        chk_eq("bnd_npc0",  bus.if_NPC_out[0], e.npc0);
        if (e.v[1]) begin
          chk_eq("bnd_ir1",  64'(bus.if_IR_out[1]), 64'(e.ir1));
          chk_eq("bnd_npc1", bus.if_NPC_out[1], e.npc1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks         = 0;
    n_fail           = 0;
    reset            = 1'b0;
    bus.Icache_valid = 1'b0;
    bus.Icache_data  = '0;
    bus.BP_F_out     = '0;
    bus.D_stall      = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk_all_zero("rst");
    reset = 1'b1;

    // Sequential fetch from RESET_PC
    cycle(1, 1'b0, 2'b00, 64'd0, 1'b0);
    chk_eq("req_after_reset", 64'(bus.Icache_req), 64'd1);
    chk_eq("addr_first", bus.Icache_addr, 64'h0);
    hit(64'h0);
    chk_eq("addr_seq8", bus.Icache_addr, 64'h8);
    hit(64'h8);
    chk_eq("addr_seq16", bus.Icache_addr, 64'h10);

    // Redirect to an upper-word PC
    cycle(1, 1'b1, 2'b00, 64'h104, 1'b0);
    chk_eq("rb_pc", bus.if_PC_reg, 64'h104);
    chk_eq("rb_addr_aligned", bus.Icache_addr, 64'h100);
    chk_eq("rb_flush", 64'(bus.F_BP_out.inst_valid), 64'd0);
    hit(64'h104);
    chk_eq("odd_next_addr", bus.Icache_addr, 64'h108);

    // Predicted-taken bubble
    cycle(1, 1'b1, 2'b00, 64'h20, 1'b0);
    hit(64'h20);
    chk_eq("pre_taken_pc", bus.if_PC_reg, 64'h28);
    cycle(1, 1'b0, 2'b01, 64'h400, 1'b0);
    chk_eq("taken_pc", bus.if_PC_reg, 64'h400);
    chk_eq("taken_bubble", 64'(bus.F_BP_out.inst_valid), 64'd0);
    hit(64'h400);
    chk_eq("taken_next_addr", bus.Icache_addr, 64'h408);

    // Miss, rollback mid-miss, drain of the late response
    cycle(1, 1'b1, 2'b00, 64'h40, 1'b0);
    cycle(0, 1'b0, 2'b00, 64'd0, 1'b0);
    chk_eq("miss_req", 64'(bus.Icache_req), 64'd1);
    chk_eq("miss_addr", bus.Icache_addr, 64'h40);
    cycle(0, 1'b1, 2'b00, 64'h800, 1'b0);
    chk_eq("drain_req", 64'(bus.Icache_req), 64'd0);
    chk_eq("drain_pc", bus.if_PC_reg, 64'h800);
    cycle(0, 1'b0, 2'b00, 64'd0, 1'b0);
    chk_eq("drain_req_hold", 64'(bus.Icache_req), 64'd0);
    cycle(2, 1'b0, 2'b00, 64'd0, 1'b0);
    chk_eq("drain_done_req", 64'(bus.Icache_req), 64'd1);
    chk_eq("drain_drop", 64'(bus.F_BP_out.inst_valid), 64'd0);
    chk_eq("drain_next_addr", bus.Icache_addr, 64'h800);
    hit(64'h800);

    // Dispatch stall, then rollback during the stall
    cycle(1, 1'b1, 2'b00, 64'h60, 1'b0);
    hit(64'h60);
    cycle(1, 1'b0, 2'b00, 64'd0, 1'b1);
    chk_eq("stall_pc", bus.if_PC_reg, 64'h68);
    chk_eq("stall_valid", 64'(bus.F_BP_out.inst_valid), 64'd3);
    chk_eq("stall_ir0", 64'(bus.if_IR_out[0]), 64'(inst(64'h60)));
    chk_eq("stall_npc0", bus.if_NPC_out[0], 64'h64);
    chk_eq("stall_npc1", bus.if_NPC_out[1], 64'h68);
    cycle(1, 1'b1, 2'b00, 64'h200, 1'b1);
    chk_eq("stall_rb_flush", 64'(bus.F_BP_out.inst_valid), 64'd0);
    chk_eq("stall_rb_pc", bus.if_PC_reg, 64'h200);
    hit(64'h200);

    // 64-bit wrap of NPC and sequential next
    cycle(1, 1'b1, 2'b00, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
    hit(64'hFFFF_FFFF_FFFF_FFF8);
    chk_eq("wrap_next", bus.Icache_addr, 64'h0);

    // Asynchronous reset while in MISS with a held bundle
    hit(64'h0);
    cycle(0, 1'b0, 2'b00, 64'd0, 1'b1);
    chk_eq("miss_hold_valid", 64'(bus.F_BP_out.inst_valid), 64'd3);
    chk_eq("miss_hold_addr", bus.Icache_addr, 64'h8);
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("async_rst");
    bus.Icache_valid = 1'b1;
    bus.Icache_data  = blk(64'h8);
    bus.D_stall      = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk_eq("rst_no_load", 64'(bus.F_BP_out.inst_valid), 64'd0);
    reset = 1'b1;
    cycle(1, 1'b0, 2'b00, 64'd0, 1'b0);
    chk_eq("rerun_addr", bus.Icache_addr, 64'h0);
    hit(64'h0);
    chk_eq("rerun_next", bus.Icache_addr, 64'h8);
    cycle(0, 1'b0, 2'b00, 64'd0, 1'b0);
    cycle(0, 1'b0, 2'b00, 64'd0, 1'b0);
    chk_eq("sb_leftover", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
- Fetch-stage PC generator and IF/ID bundle register for the 2-wide front end.
- Issues aligned 8-byte requests to the I-cache and registers up to two instructions with their NPCs.
- Presents the registered bundle to the branch predictor, which evaluates it combinationally.
- Consumes the predictor's taken/target/rollback outputs to steer the next fetch address.

Parameters:
- RESET_PC, 64'h0, fetch address loaded on reset.
- NUM_SUPER, `NUM_SUPER (2), fetch width; the logic below is written for 2.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- Icache_data  in  64  aligned 8-byte block; [31:0] is the instruction at addr, [63:32] the one at addr+4.
- Icache_valid  in  1  Icache_data is valid for the current request.
- Icache_addr  out  64  {PC[63:3],3'b0}.
- Icache_req  out  1  request active.
- BP_F_out  in  BP_F_OUT_t  fields: rollback_en, take_branch_out[1:0], take_branch_target_out[63:0], inst_valid[1:0].
- D_stall  in  1  dispatch cannot accept this cycle.
- if_IR_out  out  [NUM_SUPER][32]  registered instructions.
- if_NPC_out  out  [NUM_SUPER][64]  registered PC+4 per slot.
- F_BP_out  out  F_BP_OUT_t  inst_valid[1:0] of the registered bundle.
- if_PC_reg  out  64  current fetch PC (debug).

Behaviour:
- Reset (async, reset==0):
  - PC=RESET_PC, state=FETCH.
  - Bundle invalid; if_IR_out, if_NPC_out and F_BP_out.inst_valid all zero.
  - Icache_req goes high in the first cycle after reset deasserts.
- Alignment:
  - PC[1:0] is always 0.
  - PC[2]==0: slot0 = data[31:0] @PC, slot1 = data[63:32] @PC+4, both valid. Sequential next = PC+8.
  - PC[2]==1: slot0 = data[63:32] @PC, slot1 invalid. Sequential next = PC+4.
- NPC = slot PC+4, computed with 64-bit wrap-around arithmetic.
- Bundle registered = state FETCH && Icache_valid && !D_stall && !redirect. Taken-branch bubble latency is 1 cycle.
- redirect = BP_F_out.rollback_en, or (bundle valid && |BP_F_out.take_branch_out).
- Next-state priority (highest first):
  1. rollback_en:
     - PC <= take_branch_target_out; bundle invalidated.
     - In MISS: state <= DRAIN, else FETCH.
     - Overrides D_stall.
  2. Predicted taken on a valid bundle, with !D_stall:
     - PC <= take_branch_target_out.
     - The current I-cache response is discarded (wrong path).
     - Bundle reloads invalid; MISS -> DRAIN.
  3. D_stall:
     - Bundle and PC hold; the I-cache response is discarded and refetched.
     - State is unchanged, except FETCH && !Icache_valid -> MISS.
  4. FETCH && Icache_valid: bundle loaded; PC <= sequential next.
  5. FETCH && !Icache_valid: state <= MISS.
- States:
  - FETCH: Icache_req=1.
  - MISS: Icache_req=1, Icache_addr held stable; on Icache_valid, load bundle as in FETCH and return to FETCH.
  - DRAIN: Icache_req=0 until Icache_valid is seen. That stale data is dropped; then FETCH at the already-updated PC.
- Rollback or predicted taken while in DRAIN: PC is updated, state stays DRAIN.
- Bundle inst_valid carries the raw slot valids; BP_F_out.inst_valid masking (slot1 after a taken slot0) is applied downstream, not here.
- Bundle is cleared (invalid) when dispatch consumes it and no new bundle arrives the same cycle.

Optional Feature:
- FETCH_PERF_CNT_EN defined:
  - Adds 32-bit saturating counters: fetched instructions, miss cycles, squashed bundles.
  - Outputs fetch_cnt, miss_cycle_cnt, squash_cnt; all reset to 0.
- FETCH_PERF_CNT_EN undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared sys_defs package holds:
  - F_BP_OUT_t and BP_F_OUT_t (already shared).
  - New enum FETCH_STATE_t {FETCH, MISS, DRAIN}.
  - New struct IF_BUNDLE_t {valid[2], IR[2][32], NPC[2][64]}.
  - `FETCH_BLOCK_BYTES=8.
- One sub-module, fetch_align: combinational slot extraction and NPC/sequential-next generation from PC and Icache_data.

Test Plan:
- Reset release, RESET_PC=0, I-cache always valid -> Icache_addr sequence 0, 8, 16; both slots valid; if_NPC_out = {4,8}, then {12,16}.
- Redirect to 0x104, I-cache hit -> one bundle: slot0 IR = data[63:32], NPC 0x108, slot1 invalid; next Icache_addr 0x108.
- Bundle @0x20 with take_branch_out=2'b01, target 0x400 -> next PC 0x400, the 0x28 response dropped, one invalid bundle, then a bundle at 0x400.
- Miss at 0x40 for 3 cycles, rollback to 0x800 in the second miss cycle -> DRAIN with Icache_req=0; the late 0x40 data is dropped; the next request is 0x800.
- D_stall=1 for 2 cycles with a valid bundle @0x60 -> outputs stable, PC stays 0x68; rollback to 0x200 during the stall flushes the bundle immediately.
- Assert reset mid-MISS -> all outputs zero asynchronously; after release, fetch resumes at RESET_PC with no stale data loaded.
